// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit peripheral:
//   - tx_state_t     : transmit FSM state encoding
//   - TXDATA_OFFSET  : byte offset of the write-only transmit data register
//   - STATUS_OFFSET  : byte offset of the read-only status register
//   - STAT_*         : bit positions inside the STATUS word
//   - even_parity()  : even-parity helper for the optional parity bit
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [63:0] TXDATA_OFFSET = 64'h0000_0000_0000_0000;
    localparam logic [63:0] STATUS_OFFSET = 64'h0000_0000_0000_0008;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] byte_in);
        return ^byte_in;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through FIFO for transmit bytes.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset (empties the FIFO)
//   push, din      : write request and data; ignored while full
//   pop, dout      : read request; dout always shows the head entry
//   full, empty    : occupancy flags
//   count          : number of stored entries (0..DEPTH)
// DEPTH must be a power of two, minimum 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    // Full-FIFO pushes are dropped here even if a pop happens in the same cycle.
    always_comb begin
        wr_en_s = push & ~full;
        rd_en_s = pop & ~empty;
    end

    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_peripheral.sv
// -----------------------------------------------------------------------------
// uart_tx_peripheral
// Memory-mapped UART transmitter with a transmit FIFO.
// Register window:
//   BASE_ADDR + 0 : TXDATA (write-only, data[7:0] pushed on the write edge)
//   BASE_ADDR + 8 : STATUS (read-only: bit0 full, bit1 empty, bit2 busy,
//                   bit3 sticky overflow, bits[15:8] FIFO count)
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   data         : shared 64-bit bus; driven only while STATUS is read
//   address      : shared 64-bit address bus
//   read, write  : processor strobes
//   uart_txd     : serial output, idle high, 8N1 frames
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits (8E1 frames).
// -----------------------------------------------------------------------------
module uart_tx_peripheral
    import uart_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = 64'hFFFF_FFFF_FFFF_F000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [63:0] data,
    input  logic [63:0] address,
    input  logic        read,
    input  logic        write,
    output logic        uart_txd
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int          BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [63:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFFSET;
    localparam logic [63:0] STATUS_ADDR = BASE_ADDR + STATUS_OFFSET;

    logic              write_d_r;
    logic              overflow_r;
    tx_state_t         state_r;
    logic [BAUD_W-1:0] baud_cnt_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        tx_byte_r;
    logic              txd_r;

    logic              push_req_s;
    logic              status_rd_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;
    logic [7:0]        fifo_dout_s;
    logic              baud_done_s;
    logic              start_frame_s;
    logic              txd_next_s;
    logic [63:0]       status_s;
    logic              unused_data_s;

    // Upper data lines are part of the bus but carry nothing for TXDATA.
    assign unused_data_s = ^data[63:8];

    // Bus decode: a push happens only on the rising edge of write.
    always_comb begin
        push_req_s  = write & ~write_d_r & (address == TXDATA_ADDR);
        status_rd_s = read & (address == STATUS_ADDR);
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .CW    (CW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req_s),
        .pop   (start_frame_s),
        .din   (data[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Frame start: from IDLE, or straight out of the last STOP cycle so
    // consecutive frames have no idle gap.
    always_comb begin
        baud_done_s   = (baud_cnt_r == BAUD_LAST);
        start_frame_s = 1'b0;
        if (fifo_empty_s) begin
            start_frame_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            start_frame_s = 1'b1;
        end else if ((state_r == ST_STOP) && baud_done_s) begin
            start_frame_s = 1'b1;
        end else begin
            start_frame_s = 1'b0;
        end
    end

    // Line level for the current state; registered one cycle later, which
    // places the start bit two edges after the push edge.
    always_comb begin
        case (state_r)
            ST_IDLE:   txd_next_s = 1'b1;
            ST_START:  txd_next_s = 1'b0;
            ST_DATA:   txd_next_s = tx_byte_r[bit_idx_r];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_next_s = even_parity(tx_byte_r);
`endif
            ST_STOP:   txd_next_s = 1'b1;
            default:   txd_next_s = 1'b1;
        endcase
    end

    // STATUS word assembly.
    always_comb begin
        status_s                                 = 64'h0000_0000_0000_0000;
        status_s[STAT_FULL_BIT]                  = fifo_full_s;
        status_s[STAT_EMPTY_BIT]                 = fifo_empty_s;
        status_s[STAT_BUSY_BIT]                  = (state_r != ST_IDLE);
        status_s[STAT_OVF_BIT]                   = overflow_r;
        status_s[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count_s);
    end

    assign data     = status_rd_s ? status_s : {64{1'bz}};
    assign uart_txd = txd_r;

    // Write edge detector and sticky overflow; a drop wins over a clearing read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_d_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            write_d_r <= write;
            if (push_req_s && fifo_full_s) begin
                overflow_r <= 1'b1;
            end else if (status_rd_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Transmit FSM with baud counter, bit index and registered line output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_idx_r  <= 3'd0;
            tx_byte_r  <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            txd_r <= txd_next_s;
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= {BAUD_W{1'b0}};
                    bit_idx_r  <= 3'd0;
                    if (start_frame_s) begin
                        tx_byte_r <= fifo_dout_s;
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        bit_idx_r  <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        state_r    <= ST_STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done_s) begin
                        baud_cnt_r <= {BAUD_W{1'b0}};
                        if (start_frame_s) begin
                            tx_byte_r <= fifo_dout_s;
                            state_r   <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= {BAUD_W{1'b0}};
                    bit_idx_r  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_peripheral
// Scoreboard bench: every accepted TXDATA push queues its expected byte; an
// independent serial monitor decodes frames off uart_txd and checks them
// against the queue. Bus-level STATUS values come from an occupancy model.
// -----------------------------------------------------------------------------
module tb_uart_tx_peripheral;

    localparam logic [63:0] BASE  = 64'hFFFF_FFFF_FFFF_F000;
    localparam logic [63:0] TXD_A = BASE;
    localparam logic [63:0] STS_A = BASE + 64'd8;
    localparam int N     = 16;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FB = 10 + PAR;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read  = 1'b0;
    logic        write = 1'b0;
    logic        wr_en = 1'b0;
    logic [63:0] address = 64'd0;
    logic [63:0] wr_val  = 64'd0;
    logic        uart_txd;
    wire  [63:0] data_bus;

    assign data_bus = wr_en ? wr_val : {64{1'bz}};

    uart_tx_peripheral #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data     (data_bus),
        .address  (address),
        .read     (read),
        .write    (write),
        .uart_txd (uart_txd)
    );

    initial forever #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          passed = 0;
    int          total  = 0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [63:0] status_word(input int cnt, input bit busy, input bit ovf);
        logic [63:0] w;
        w = 64'd0;
        w[15:8] = 8'(cnt);
        w[3] = ovf;
        w[2] = busy;
        w[1] = (cnt == 0);
        w[0] = (cnt == DEPTH);
        return w;
    endfunction

    // Serial monitor: detect start bit, sample each bit mid-period.
    initial begin
        bit         active = 0;
        int         cnt = 0;
        int         k;
        logic [7:0] rx = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                active = 0;
            end else if (!active) begin
                if (uart_txd == 1'b0) begin
                    active = 1;
                    cnt = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt >= N/2 && ((cnt - N/2) % N) == 0) begin
                    k = (cnt - N/2) / N;
                    if (k == 0) begin
                        chk("start_bit", 64'(uart_txd), 64'd0);
                    end else if (k <= 8) begin
                        rx[k-1] = uart_txd;
                    end else if (k == 9 && PAR == 1) begin
                        chk("parity_bit", 64'(uart_txd), 64'($countones(rx) % 2));
                    end else begin
                        chk("stop_bit", 64'(uart_txd), 64'd1);
                        if (exp_q.size() == 0) begin
                            total++;
                            $display("FAIL unexpected_frame: got byte %h expected no frame", rx);
                        end else begin
                            chk("frame_byte", 64'(rx), 64'(exp_q.pop_front()));
                        end
                        active = 0;
                    end
                end
            end
        end
    end

    task automatic do_write(input logic [63:0] a, input logic [63:0] v, input int hold);
        @(negedge clock);
        address = a; wr_val = v; wr_en = 1'b1; write = 1'b1;
        repeat (hold) @(negedge clock);
        write = 1'b0; wr_en = 1'b0;
    endtask

    task automatic read_status(output logic [63:0] v);
        @(negedge clock);
        address = STS_A; read = 1'b1;
        #1 v = data_bus;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic wait_idle();
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 24 * FB * N; i++) begin
            read_status(v);
            if (v == 64'h2) break;
        end
        chk("idle_status", v, 64'h2);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] a;
        logic [63:0] d;
        int          s0;
        int          mcnt;
        bit          movf;

        repeat (3) @(negedge clock);
        chk("reset_txd", 64'(uart_txd), 64'd1);
        reset = 1'b0;
        read_status(v);
        chk("reset_status", v, 64'h2);

        // 8'h55: start bit exactly two edges after the push edge.
        exp_q.push_back(8'h55);
        @(negedge clock);
        address = TXD_A; wr_val = 64'hDEAD_BEEF_0000_0055; wr_en = 1'b1; write = 1'b1;
        @(posedge clock);
        #1 write = 1'b0; wr_en = 1'b0;
        @(posedge clock);
        #1 chk("txd_high_edge1", 64'(uart_txd), 64'd1);
        @(posedge clock);
        #1 chk("txd_low_edge2", 64'(uart_txd), 64'd0);
        wait_idle();

        // Held write pushes once.
        s0 = start_q.size();
        exp_q.push_back(8'hA3);
        do_write(TXD_A, 64'h0000_0000_0000_00A3, 5);
        wait_idle();
        chk("held_write_frames", 64'(start_q.size() - s0), 64'd1);

        // Back-to-back frames with no gap.
        s0 = start_q.size();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        do_write(TXD_A, 64'h01, 1);
        do_write(TXD_A, 64'h02, 1);
        read_status(v);
        chk("b2b_status", v, status_word(1, 1'b1, 1'b0));
        wait_idle();
        if (start_q.size() >= s0 + 2)
            chk("b2b_spacing", 64'(start_q[s0+1] - start_q[s0]), 64'(FB * N));
        else
            chk("b2b_frames", 64'(start_q.size() - s0), 64'd2);

        // Overflow: one byte in flight, then 17 pushes into 16 slots.
        exp_q.push_back(8'hC0);
        do_write(TXD_A, 64'hC0, 1);
        repeat (4) @(negedge clock);
        mcnt = 0; movf = 1'b0;
        for (int i = 0; i < 17; i++) begin
            d = {$urandom, $urandom};
            if (mcnt < DEPTH) begin
                mcnt++;
                exp_q.push_back(d[7:0]);
            end else begin
                movf = 1'b1;
            end
            do_write(TXD_A, d, 1);
        end
        read_status(v);
        chk("ovf_status_set", v, status_word(mcnt, 1'b1, movf));
        read_status(v);
        chk("ovf_status_clear", v, status_word(mcnt, 1'b1, 1'b0));
        wait_idle();

        // Randomized bursts, including ignored addresses and held writes.
        for (int b = 0; b < 3; b++) begin
            int n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                int sel = $urandom_range(0, 5);
                a = (sel == 0) ? STS_A : ((sel == 1) ? BASE + 64'd16 : TXD_A);
                d = {$urandom, $urandom};
                if (a == TXD_A) exp_q.push_back(d[7:0]);
                do_write(a, d, $urandom_range(1, 4));
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
            wait_idle();
        end

        // Reset during bit 4 of 8'hFF with three bytes queued.
        s0 = start_q.size();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        do_write(TXD_A, 64'hFF, 1);
        do_write(TXD_A, 64'h11, 1);
        do_write(TXD_A, 64'h22, 1);
        do_write(TXD_A, 64'h33, 1);
        for (int i = 0; i < 4 * N && start_q.size() == s0; i++) @(negedge clock);
        if (start_q.size() == s0) begin
            chk("reset_test_frame_started", 64'd0, 64'd1);
        end else begin
            while (cyc < start_q[s0] + 5 * N + N / 2) @(negedge clock);
            #1 reset = 1'b1;
            exp_q.delete();
            #1 chk("midframe_reset_txd", 64'(uart_txd), 64'd1);
            repeat (2) @(negedge clock);
            reset = 1'b0;
            read_status(v);
            chk("post_reset_status", v, 64'h2);
            s0 = start_q.size();
            repeat (4 * FB * N) @(negedge clock);
            chk("no_frames_after_reset", 64'(start_q.size() - s0), 64'd0);
            chk("txd_idle_after_reset", 64'(uart_txd), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
